// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand select, ALU/MEM/WB control decode, load-use bubbles.
// Optional feature: define WB_BYPASS_EN to forward same-cycle writeback data into rs/rt.
module id_ex_stage #(
  parameter int SIZE     = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [5:0]          in_opcode,
  input  logic [REG_BITS-1:0] in_rs_addr,
  input  logic [REG_BITS-1:0] in_rt_addr,
  input  logic [REG_BITS-1:0] in_rd_addr,
  input  logic [SIZE-1:0]     in_rs_data,
  input  logic [SIZE-1:0]     in_rt_data,
  input  logic [15:0]         in_imm,
  input  logic                wb_we,
  input  logic [REG_BITS-1:0] wb_addr,
  input  logic [SIZE-1:0]     wb_data,
  output logic                hazard_stall,
  output logic                ex_valid,
  output logic [5:0]          ex_control,
  output logic [SIZE-1:0]     ex_a,
  output logic [SIZE-1:0]     ex_b,
  output logic [SIZE-1:0]     ex_store_data,
  output logic [REG_BITS-1:0] ex_rd_addr,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_branch
);

  logic            w_legal, w_rw, w_mr, w_mw, w_br, w_use_imm, w_rs_use, w_rt_use;
  logic            w_take;
  logic [SIZE-1:0] w_rs_val, w_rt_val, w_imm_ext;

  always_comb begin
    w_legal   = 1'b0;
    w_rw      = 1'b0;
    w_mr      = 1'b0;
    w_mw      = 1'b0;
    w_br      = 1'b0;
    w_use_imm = 1'b0;
    w_rs_use  = 1'b0;
    w_rt_use  = 1'b0;
    unique case (in_opcode)
      6'h00: w_legal = 1'b1;
      6'h10: begin w_legal = 1'b1; w_rw = 1'b1; w_rs_use = 1'b1; end
      6'h12, 6'h13, 6'h14, 6'h15: begin
        w_legal = 1'b1; w_rw = 1'b1; w_rs_use = 1'b1; w_rt_use = 1'b1;
      end
      6'h20: begin w_legal = 1'b1; w_br = 1'b1; w_rs_use = 1'b1; w_rt_use = 1'b1; end
      6'h32, 6'h33, 6'h34, 6'h35: begin
        w_legal = 1'b1; w_rw = 1'b1; w_use_imm = 1'b1; w_rs_use = 1'b1;
      end
      6'h39: begin w_legal = 1'b1; w_rw = 1'b1; w_use_imm = 1'b1; end
      6'h3B: begin
        w_legal = 1'b1; w_rw = 1'b1; w_mr = 1'b1; w_use_imm = 1'b1; w_rs_use = 1'b1;
      end
      6'h3C: begin
        w_legal = 1'b1; w_mw = 1'b1; w_use_imm = 1'b1; w_rs_use = 1'b1; w_rt_use = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef WB_BYPASS_EN
  assign w_rs_val = (wb_we && wb_addr != '0 && wb_addr == in_rs_addr) ? wb_data : in_rs_data;
  assign w_rt_val = (wb_we && wb_addr != '0 && wb_addr == in_rt_addr) ? wb_data : in_rt_data;
`else
  assign w_rs_val = in_rs_data;
  assign w_rt_val = in_rt_data;
`endif

  assign w_imm_ext = {{(SIZE-16){in_imm[15]}}, in_imm};

  assign hazard_stall = ex_valid && ex_mem_read && (ex_rd_addr != '0) && in_valid &&
                        ((w_rs_use && in_rs_addr == ex_rd_addr) ||
                         (w_rt_use && in_rt_addr == ex_rd_addr));

  assign w_take = in_valid && w_legal && !hazard_stall;

  // Flush shares the reset path: both force a bubble regardless of stall.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid      <= 1'b0;
      ex_control    <= '0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_store_data <= '0;
      ex_rd_addr    <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= w_take;
      ex_control    <= w_take ? in_opcode : '0;
      ex_a          <= w_take ? w_rs_val : '0;
      ex_b          <= w_take ? (w_use_imm ? w_imm_ext : w_rt_val) : '0;
      ex_store_data <= (w_take && w_mw) ? w_rt_val : '0;
      ex_rd_addr    <= w_take ? in_rd_addr : '0;
      ex_reg_write  <= w_take && w_rw;
      ex_mem_read   <= w_take && w_mr;
      ex_mem_write  <= w_take && w_mw;
      ex_branch     <= w_take && w_br;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized run against a reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, wb_we;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr, wb_addr;
  logic [31:0] in_rs_data, in_rt_data, wb_data;
  logic [15:0] in_imm;
  logic        hazard_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [5:0]  ex_control;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [4:0]  ex_rd_addr;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        valid;
    logic [5:0]  ctl;
    logic [31:0] a, b, sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, br;
  } ex_t;

  ex_t m = '0;

  localparam logic [5:0] LEGAL [14] = '{6'h00, 6'h10, 6'h12, 6'h13, 6'h14, 6'h15, 6'h20,
                                        6'h32, 6'h33, 6'h34, 6'h35, 6'h39, 6'h3B, 6'h3C};

  id_ex_stage #(.SIZE(32), .REG_BITS(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_opcode(in_opcode), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rd_addr(in_rd_addr), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_control(ex_control),
    .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch)
  );

  always #5 clk = ~clk;

  function automatic ex_t dut_state();
    return {ex_valid, ex_control, ex_a, ex_b, ex_store_data, ex_rd_addr,
            ex_reg_write, ex_mem_read, ex_mem_write, ex_branch};
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    foreach (LEGAL[i]) if (LEGAL[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] src_val(logic [4:0] addr, logic [31:0] rf);
`ifdef WB_BYPASS_EN
    if (wb_we && wb_addr != 0 && wb_addr == addr) return wb_data;
`endif
    return rf;
  endfunction

  function automatic bit model_hazard();
    bit rs_used, rt_used;
    rs_used = is_legal(in_opcode) && !(in_opcode inside {6'h00, 6'h39});
    rt_used = in_opcode inside {6'h12, 6'h13, 6'h14, 6'h15, 6'h20, 6'h3C};
    return m.valid && m.mr && m.rd != 0 && in_valid &&
           ((rs_used && in_rs_addr == m.rd) || (rt_used && in_rt_addr == m.rd));
  endfunction

  function automatic ex_t model_next();
    ex_t n = '0;
    if (rst || flush) return '0;
    if (stall) return m;
    if (model_hazard() || !in_valid || !is_legal(in_opcode)) return '0;
    n.valid = 1'b1;
    n.ctl   = in_opcode;
    n.a     = src_val(in_rs_addr, in_rs_data);
    n.b     = (in_opcode inside {6'h32, 6'h33, 6'h34, 6'h35, 6'h39, 6'h3B, 6'h3C})
              ? 32'(signed'(in_imm)) : src_val(in_rt_addr, in_rt_data);
    n.sd    = (in_opcode == 6'h3C) ? src_val(in_rt_addr, in_rt_data) : 32'h0;
    n.rd    = in_rd_addr;
    n.rw    = in_opcode inside {6'h10, 6'h12, 6'h13, 6'h14, 6'h15,
                                6'h32, 6'h33, 6'h34, 6'h35, 6'h39, 6'h3B};
    n.mr    = in_opcode == 6'h3B;
    n.mw    = in_opcode == 6'h3C;
    n.br    = in_opcode == 6'h20;
    return n;
  endfunction

  task automatic tick();
    ex_t nxt = model_next();
    @(posedge clk);
    #1;
    m = nxt;
  endtask

  task automatic rand_inputs();
    in_valid   = ($urandom_range(0, 9) != 0);
    in_opcode  = ($urandom_range(0, 6) != 0) ? LEGAL[$urandom_range(0, 13)] : 6'($urandom);
    in_rs_addr = 5'($urandom_range(0, 3));
    in_rt_addr = 5'($urandom_range(0, 3));
    in_rd_addr = 5'($urandom_range(0, 3));
    in_rs_data = $urandom;
    in_rt_data = $urandom;
    in_imm     = 16'($urandom);
    wb_we      = 1'($urandom);
    wb_addr    = 5'($urandom_range(0, 3));
    wb_data    = $urandom;
  endtask

  task automatic drive(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                       logic [31:0] rsd, logic [31:0] rtd, logic [15:0] imm);
    in_valid = 1'b1; in_opcode = op; in_rs_addr = rs; in_rt_addr = rt; in_rd_addr = rd;
    in_rs_data = rsd; in_rt_data = rtd; in_imm = imm;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      tick();
      vectors++;
      if (dut_state() !== ex_t'(0)) begin
        miscompares++;
        $display("FAIL reset_state got=%h exp=0", dut_state());
      end
      vectors++;
      if (hazard_stall !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hazard got=%b exp=0", hazard_stall);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    drive(6'h32, 5'd3, 5'd9, 5'd6, 32'd5, 32'h1234, 16'hFFFE);
    tick();
    vectors++;
    if (ex_control !== 6'h32 || ex_a !== 32'd5 || ex_b !== 32'hFFFF_FFFE ||
        ex_reg_write !== 1'b1 || ex_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL addi got ctl=%h a=%h b=%h rw=%b v=%b exp ctl=32 a=5 b=fffffffe rw=1 v=1",
               ex_control, ex_a, ex_b, ex_reg_write, ex_valid);
    end
    vectors++;
    if (dut_state() !== m) begin
      miscompares++;
      $display("FAIL addi_full got=%h exp=%h", dut_state(), m);
    end
  endtask

  task automatic test_load_use();
    drive(6'h3B, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 16'h0008);
    tick();
    drive(6'h10, 5'd4, 5'd2, 5'd5, 32'h11, 32'h22, 16'h0);
    #1;
    vectors++;
    if (hazard_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL load_use_hazard got=%b exp=1", hazard_stall);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b0 || ex_control !== 6'h00 || dut_state() !== m) begin
      miscompares++;
      $display("FAIL load_use_bubble got=%h exp=%h", dut_state(), m);
    end
    vectors++;
    if (hazard_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL load_use_release got=%b exp=0", hazard_stall);
    end
    tick();
    vectors++;
    if (ex_control !== 6'h10 || ex_a !== 32'h11 || ex_b !== 32'h22 || ex_rd_addr !== 5'd5) begin
      miscompares++;
      $display("FAIL load_use_add got ctl=%h a=%h b=%h rd=%0d exp ctl=10 a=11 b=22 rd=5",
               ex_control, ex_a, ex_b, ex_rd_addr);
    end
  endtask

  task automatic test_stall_flush();
    ex_t held;
    drive(6'h3C, 5'd2, 5'd3, 5'd0, 32'hCAFE, 32'hBEEF, 16'h8001);
    tick();
    held = m;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      stall = 1'b1;
      tick();
      vectors++;
      if (dut_state() !== held) begin
        miscompares++;
        $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, dut_state(), held);
      end
    end
    flush = 1'b1;
    tick();
    vectors++;
    if (dut_state() !== ex_t'(0)) begin
      miscompares++;
      $display("FAIL flush_over_stall got=%h exp=0", dut_state());
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_illegal();
    drive(6'h3F, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h3);
    tick();
    vectors++;
    if (ex_valid !== 1'b0 || ex_control !== 6'h00 || dut_state() !== ex_t'(0)) begin
      miscompares++;
      $display("FAIL illegal_op got=%h exp=0", dut_state());
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_a;
`ifdef WB_BYPASS_EN
    exp_a = 32'hAA55;
`else
    exp_a = 32'h0;
`endif
    drive(6'h10, 5'd7, 5'd1, 5'd2, 32'h0, 32'h9, 16'h0);
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hAA55;
    tick();
    vectors++;
    if (ex_a !== exp_a) begin
      miscompares++;
      $display("FAIL wb_bypass got=%h exp=%h", ex_a, exp_a);
    end
    wb_we = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst   = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 19) == 0);
      #1;
      vectors++;
      if (hazard_stall !== model_hazard()) begin
        miscompares++;
        $display("FAIL rand_hazard i=%0d got=%b exp=%b", i, hazard_stall, model_hazard());
      end
      tick();
      vectors++;
      if (dut_state() !== m) begin
        miscompares++;
        $display("FAIL rand_state i=%0d got=%h exp=%h", i, dut_state(), m);
      end
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_inputs();
    @(negedge clk);
    test_reset();
    test_addi();
    test_load_use();
    test_stall_flush();
    test_illegal();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
